alu_result_packer: RTL and testbench
====================================

Name: alu_result_packer

Overview:
- Downstream consumer of the ALU's four unit outputs.
- Captures each ALU result when the unit's valid flag pulses, tags it with a source/carry header, and serializes it into a byte frame for the UART transmitter.
- Holds a one-entry pending buffer so one result can queue behind a frame already in flight; further results are dropped and flagged.
- Sits between the ALU outputs and the UART TX parallel-data interface.

Parameters:
- DATA_WIDTH, 16, width of ALU result buses; must be a multiple of 8 and at least 8. NBYTES = DATA_WIDTH/8.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- Arith_OUT  input  DATA_WIDTH  arithmetic result.
- carry_OUT  input  1  arithmetic carry.
- Arith_flag  input  1  arithmetic result valid, 1-cycle pulse.
- Logic_OUT  input  DATA_WIDTH  logic result.
- Logic_flag  input  1  logic result valid.
- CMP_OUT  input  1  compare result, zero-extended to DATA_WIDTH.
- CMP_flag  input  1  compare result valid.
- SHIFT_OUT  input  DATA_WIDTH  shift result.
- SHIFT_flag  input  1  shift result valid.
- TX_BUSY  input  1  UART TX busy.
- CLR_OVR  input  1  clears OVERRUN.
- TX_P_DATA  output  8  byte to transmit.
- TX_D_VLD  output  1  byte valid, 1-cycle pulse.
- PACK_BUSY  output  1  high when FSM not IDLE or pending buffer full.
- OVERRUN  output  1  sticky: result dropped.

Behaviour:
- Reset (async, RST=0): FSM to IDLE; TX_P_DATA=0, TX_D_VLD=0, PACK_BUSY=0, OVERRUN=0; active and pending buffers invalid; byte index=0. TX_D_VLD drops immediately, even mid-frame. The partial frame is abandoned and not resumed.
- Capture:
  - Result is captured on any cycle where at least one flag is high.
  - If several flags are high, priority is Arith > Logic > CMP > Shift; only the winner is captured.
  - Source code src: 00 arith, 01 logic, 10 cmp, 11 shift.
- Header byte = {5'b10100, carry, src[1:0]}. carry = carry_OUT for arith, 0 otherwise.
- Frame: header, then the result LSB-first, NBYTES bytes. Total 1+NBYTES bytes (3 at default).
- Buffering:
  - Capture while IDLE with pending empty: loads the active register; FSM enters ISSUE next cycle.
  - Capture while a frame is active and pending empty: loads pending.
  - Capture while pending full: the result is dropped and OVERRUN is set on the next edge.
  - Same cycle the last byte completes, pending promotes to active and a new capture loads pending. No overrun in this case.
- FSM states IDLE, ISSUE, WAIT_HI, WAIT_LO:
  - IDLE: go to ISSUE when active is valid.
  - ISSUE: when TX_BUSY=0, drive TX_P_DATA=current byte with TX_D_VLD=1 for exactly that cycle, then go to WAIT_HI. When TX_BUSY=1, stay in ISSUE with TX_D_VLD=0.
  - WAIT_HI: wait for TX_BUSY=1, then go to WAIT_LO.
  - WAIT_LO: wait for TX_BUSY=0. If this was not the last byte, increment the index and go to ISSUE. If it was the last byte, clear the index and go to ISSUE when pending is valid (after promoting it), else go to IDLE.
- TX_P_DATA holds the last issued byte until the next issue.
- Latency: flag at cycle N gives the header with TX_D_VLD=1 at cycle N+1, if TX_BUSY=0.
- OVERRUN is set on a drop and cleared by CLR_OVR=1. Set wins over a same-cycle clear.
- PACK_BUSY = (state!=IDLE) | pending_valid, registered with the state.

Test Plan:
- Reset then Arith_flag pulse, Arith_OUT=16'hBEEF, carry_OUT=1, TX model busy for 10 cycles per byte → bytes A4, EF, BE in order. First TX_D_VLD lands one cycle after the flag; PACK_BUSY falls after the third byte.
- CMP_flag with CMP_OUT=1 → frame A2, 01, 00. Simultaneous Arith_flag+SHIFT_flag (Arith_OUT=0x0001, carry=0, SHIFT_OUT=0x8000) → only the arith frame A0, 01, 00 is sent.
- Logic result 0x1234, then shift result 0x00F0 two cycles later → logic frame A1, 34, 12, then shift frame A3, F0, 00. OVERRUN stays 0.
- Three results during one frame → third dropped; OVERRUN=1 the cycle after. CLR_OVR pulse → 0. CLR_OVR coincident with a new drop → stays 1.
- TX_BUSY held high for 50 cycles before a capture → TX_D_VLD stays 0 until TX_BUSY falls, then the header issues in that cycle.
- RST asserted while in WAIT_LO of byte 2 → TX_D_VLD, PACK_BUSY, OVERRUN go 0 immediately. After release, a new result produces a fresh full frame starting with its header.

Source files
------------

// File: rtl/alu_result_packer.sv
// Captures ALU unit results, tags them with a source/carry header and streams
// them LSB-first as byte frames into a UART TX parallel interface.
module alu_result_packer #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] Arith_OUT,
  input  logic                  carry_OUT,
  input  logic                  Arith_flag,
  input  logic [DATA_WIDTH-1:0] Logic_OUT,
  input  logic                  Logic_flag,
  input  logic                  CMP_OUT,
  input  logic                  CMP_flag,
  input  logic [DATA_WIDTH-1:0] SHIFT_OUT,
  input  logic                  SHIFT_flag,
  input  logic                  TX_BUSY,
  input  logic                  CLR_OVR,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  output logic                  PACK_BUSY,
  output logic                  OVERRUN
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int IDXW   = $clog2(NBYTES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] act_data_q, act_data_d;
  logic [2:0]            act_tag_q, act_tag_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
  logic [2:0]            pend_tag_q, pend_tag_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  ovr_q, ovr_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;

  logic                  cap;
  logic [DATA_WIDTH-1:0] cap_data;
  logic [2:0]            cap_tag;
  logic [7:0]            cur_byte;
  logic                  issue;
  logic                  last_byte;
  logic                  frame_done;

  // Fixed-priority select of the winning unit; tag is {carry, src}.
  always_comb begin
    cap      = Arith_flag | Logic_flag | CMP_flag | SHIFT_flag;
    cap_data = SHIFT_OUT;
    cap_tag  = 3'b011;
    if (Arith_flag) begin
      cap_data = Arith_OUT;
      cap_tag  = {carry_OUT, 2'b00};
    end else if (Logic_flag) begin
      cap_data = Logic_OUT;
      cap_tag  = 3'b001;
    end else if (CMP_flag) begin
      cap_data = {{(DATA_WIDTH-1){1'b0}}, CMP_OUT};
      cap_tag  = 3'b010;
    end
  end

  always_comb begin
    cur_byte = {5'b10100, act_tag_q};
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDXW'(i + 1)) cur_byte = act_data_q[i*8 +: 8];
    end
  end

  assign issue      = (state_q == ISSUE) && !TX_BUSY;
  assign last_byte  = (idx_q == IDXW'(NBYTES));
  assign frame_done = (state_q == WAIT_LO) && !TX_BUSY && last_byte;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    act_data_d   = act_data_q;
    act_tag_d    = act_tag_q;
    pend_data_d  = pend_data_q;
    pend_tag_d   = pend_tag_q;
    pend_valid_d = pend_valid_q;
    ovr_d        = CLR_OVR ? 1'b0 : ovr_q;
    tx_data_d    = tx_data_q;

    unique case (state_q)
      IDLE: ;
      ISSUE: begin
        if (!TX_BUSY) begin
          tx_data_d = cur_byte;
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (TX_BUSY) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!TX_BUSY) begin
          if (!last_byte) begin
            idx_d   = idx_q + 1'b1;
            state_d = ISSUE;
          end else begin
            idx_d = '0;
            if (pend_valid_q) begin
              act_data_d   = pend_data_q;
              act_tag_d    = pend_tag_q;
              pend_valid_d = 1'b0;
              state_d      = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame finishing this cycle frees a slot, so a new capture never drops then.
    if (cap) begin
      if (state_q == IDLE || (frame_done && !pend_valid_q)) begin
        act_data_d = cap_data;
        act_tag_d  = cap_tag;
        state_d    = ISSUE;
      end else if (!pend_valid_q || frame_done) begin
        pend_data_d  = cap_data;
        pend_tag_d   = cap_tag;
        pend_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    busy_d = (state_d != IDLE) | pend_valid_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      act_data_q   <= '0;
      act_tag_q    <= '0;
      pend_data_q  <= '0;
      pend_tag_q   <= '0;
      pend_valid_q <= 1'b0;
      ovr_q        <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      act_data_q   <= act_data_d;
      act_tag_q    <= act_tag_d;
      pend_data_q  <= pend_data_d;
      pend_tag_q   <= pend_tag_d;
      pend_valid_q <= pend_valid_d;
      ovr_q        <= ovr_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
    end
  end

  assign TX_D_VLD  = issue;
  assign TX_P_DATA = issue ? cur_byte : tx_data_q;
  assign PACK_BUSY = busy_q;
  assign OVERRUN   = ovr_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Directed-vector bench for alu_result_packer with a simple UART TX busy model.
module tb_alu_result_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] Arith_OUT;
  logic        carry_OUT;
  logic        Arith_flag;
  logic [15:0] Logic_OUT;
  logic        Logic_flag;
  logic        CMP_OUT;
  logic        CMP_flag;
  logic [15:0] SHIFT_OUT;
  logic        SHIFT_flag;
  logic        TX_BUSY;
  logic        CLR_OVR;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        PACK_BUSY;
  logic        OVERRUN;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [7:0]  rxQ[$];

  alu_result_packer #(.DATA_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_OUT(Arith_OUT), .carry_OUT(carry_OUT), .Arith_flag(Arith_flag),
    .Logic_OUT(Logic_OUT), .Logic_flag(Logic_flag),
    .CMP_OUT(CMP_OUT), .CMP_flag(CMP_flag),
    .SHIFT_OUT(SHIFT_OUT), .SHIFT_flag(SHIFT_flag),
    .TX_BUSY(TX_BUSY), .CLR_OVR(CLR_OVR),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
    .PACK_BUSY(PACK_BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Record every byte handed to the transmitter.
  always @(negedge CLK) begin
    if (TX_D_VLD === 1'b1) rxQ.push_back(TX_P_DATA);
  end

  // UART model: goes busy just after accepting a byte and stays busy ~10 cycles.
  always begin
    @(negedge CLK);
    if (TX_D_VLD === 1'b1) begin
      @(posedge CLK);
      #1 TX_BUSY = 1'b1;
      repeat (9) @(posedge CLK);
      #1 TX_BUSY = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: actual %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; holds the flags across exactly one rising edge.
  task automatic applyStimulus(input logic [3:0] flags, input logic [15:0] a, input logic c,
                               input logic [15:0] l, input logic cmpv, input logic [15:0] s);
    Arith_OUT = a; carry_OUT = c; Logic_OUT = l; CMP_OUT = cmpv; SHIFT_OUT = s;
    {Arith_flag, Logic_flag, CMP_flag, SHIFT_flag} = flags;
    @(negedge CLK);
    {Arith_flag, Logic_flag, CMP_flag, SHIFT_flag} = 4'b0000;
  endtask

  task automatic waitBytes(input int n);
    int cyc = 0;
    while (rxQ.size() < n && cyc < 2000) begin
      @(negedge CLK); #1;
      cyc++;
    end
    checkOutput("bytes_received", rxQ.size(), n);
  endtask

  task automatic waitIdle();
    int cyc = 0;
    while ((PACK_BUSY !== 1'b0 || TX_BUSY !== 1'b0) && cyc < 2000) begin
      @(negedge CLK); #1;
      cyc++;
    end
    checkOutput("idle_pack_busy", PACK_BUSY, 0);
  endtask

  task automatic checkFrame(input string tag, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] exp[3];
    logic [31:0] got;
    exp[0] = b0; exp[1] = b1; exp[2] = b2;
    for (int i = 0; i < 3; i++) begin
      got = (rxQ.size() > 0) ? {24'h0, rxQ.pop_front()} : 32'hDEAD;
      checkOutput($sformatf("%s_byte%0d", tag, i), got, {24'h0, exp[i]});
    end
  endtask

  initial begin
    RST = 1'b0; TX_BUSY = 1'b0; CLR_OVR = 1'b0;
    Arith_OUT = '0; carry_OUT = 1'b0; Arith_flag = 1'b0;
    Logic_OUT = '0; Logic_flag = 1'b0; CMP_OUT = 1'b0; CMP_flag = 1'b0;
    SHIFT_OUT = '0; SHIFT_flag = 1'b0;

    repeat (3) @(negedge CLK);
    #1;
    checkOutput("reset_tx_data", TX_P_DATA, 0);
    checkOutput("reset_tx_vld", TX_D_VLD, 0);
    checkOutput("reset_pack_busy", PACK_BUSY, 0);
    checkOutput("reset_overrun", OVERRUN, 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Arith with carry: header one cycle after the flag, busy drops after the frame.
    applyStimulus(4'b1000, 16'hBEEF, 1'b1, 16'h0, 1'b0, 16'h0);
    #1;
    checkOutput("latency_vld", TX_D_VLD, 1);
    checkOutput("latency_header", TX_P_DATA, 8'hA4);
    waitBytes(3);
    checkOutput("busy_after_third_byte", PACK_BUSY, 1);
    checkFrame("arith", 8'hA4, 8'hEF, 8'hBE);
    waitIdle();
    checkOutput("tx_data_holds_last", TX_P_DATA, 8'hBE);

    applyStimulus(4'b0010, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    waitBytes(3);
    waitIdle();
    checkFrame("cmp", 8'hA2, 8'h01, 8'h00);

    // Arith beats shift when both fire together.
    applyStimulus(4'b1001, 16'h0001, 1'b0, 16'h0, 1'b0, 16'h8000);
    waitBytes(3);
    waitIdle();
    checkOutput("priority_frame_len", rxQ.size(), 3);
    checkFrame("priority", 8'hA0, 8'h01, 8'h00);

    // Second result queues in the pending buffer.
    applyStimulus(4'b0100, 16'h0, 1'b0, 16'h1234, 1'b0, 16'h0);
    @(negedge CLK);
    applyStimulus(4'b0001, 16'h0, 1'b0, 16'h0, 1'b0, 16'h00F0);
    waitBytes(6);
    waitIdle();
    checkFrame("logic", 8'hA1, 8'h34, 8'h12);
    checkFrame("shift", 8'hA3, 8'hF0, 8'h00);
    checkOutput("no_overrun_pending", OVERRUN, 0);

    // Three back-to-back results: the third is dropped.
    applyStimulus(4'b1000, 16'h1111, 1'b0, 16'h0, 1'b0, 16'h0);
    applyStimulus(4'b0100, 16'h0, 1'b0, 16'h2222, 1'b0, 16'h0);
    #1 checkOutput("overrun_before_drop", OVERRUN, 0);
    applyStimulus(4'b0001, 16'h0, 1'b0, 16'h0, 1'b0, 16'h3333);
    #1 checkOutput("overrun_after_drop", OVERRUN, 1);
    waitBytes(6);
    waitIdle();
    checkFrame("ovr_first", 8'hA0, 8'h11, 8'h11);
    checkFrame("ovr_second", 8'hA1, 8'h22, 8'h22);
    checkOutput("ovr_no_third_frame", rxQ.size(), 0);
    checkOutput("overrun_sticky", OVERRUN, 1);
    CLR_OVR = 1'b1;
    @(negedge CLK);
    CLR_OVR = 1'b0;
    #1 checkOutput("overrun_cleared", OVERRUN, 0);

    // A drop coincident with a clear keeps the flag set.
    @(negedge CLK);
    applyStimulus(4'b1000, 16'h4444, 1'b1, 16'h0, 1'b0, 16'h0);
    applyStimulus(4'b0100, 16'h0, 1'b0, 16'h5555, 1'b0, 16'h0);
    CLR_OVR = 1'b1;
    applyStimulus(4'b0010, 16'h0, 1'b0, 16'h0, 1'b1, 16'h0);
    CLR_OVR = 1'b0;
    #1 checkOutput("overrun_set_wins", OVERRUN, 1);
    waitBytes(6);
    waitIdle();
    checkFrame("setwins_first", 8'hA4, 8'h44, 8'h44);
    rxQ.delete();
    CLR_OVR = 1'b1;
    @(negedge CLK);
    CLR_OVR = 1'b0;

    // Transmitter busy for a long stretch before and after the capture.
    TX_BUSY = 1'b1;
    repeat (50) @(negedge CLK);
    applyStimulus(4'b0001, 16'h0, 1'b0, 16'h0, 1'b0, 16'h5A5A);
    repeat (10) @(negedge CLK);
    #1;
    checkOutput("busy_hold_no_vld", TX_D_VLD, 0);
    checkOutput("busy_hold_no_bytes", rxQ.size(), 0);
    @(posedge CLK);
    #1 TX_BUSY = 1'b0;
    #1;
    checkOutput("busy_release_vld", TX_D_VLD, 1);
    checkOutput("busy_release_header", TX_P_DATA, 8'hA3);
    waitBytes(3);
    waitIdle();
    checkFrame("busy_hold", 8'hA3, 8'h5A, 8'h5A);

    // Reset in the middle of byte 2 abandons the frame and the queued result.
    @(negedge CLK);
    applyStimulus(4'b1000, 16'h0102, 1'b1, 16'h0, 1'b0, 16'h0);
    applyStimulus(4'b0100, 16'h0, 1'b0, 16'h0304, 1'b0, 16'h0);
    applyStimulus(4'b0010, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
    waitBytes(2);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("pre_reset_overrun", OVERRUN, 1);
    checkOutput("pre_reset_busy", PACK_BUSY, 1);
    #1 RST = 1'b0;
    #1;
    checkOutput("mid_reset_vld", TX_D_VLD, 0);
    checkOutput("mid_reset_busy", PACK_BUSY, 0);
    checkOutput("mid_reset_overrun", OVERRUN, 0);
    checkOutput("mid_reset_tx_data", TX_P_DATA, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    waitIdle();
    rxQ.delete();
    @(negedge CLK);
    applyStimulus(4'b0100, 16'h0, 1'b0, 16'hCAFE, 1'b0, 16'h0);
    waitBytes(3);
    waitIdle();
    checkOutput("post_reset_frame_len", rxQ.size(), 3);
    checkFrame("post_reset", 8'hA1, 8'hFE, 8'hCA);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
